imem_fetch_arbiter: RTL and testbench

//  Fetch sequencer and write-port arbiter for the instruction memory bank of the 5-stage MIPS pipeline.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_write_arb.sv | 34 +++
 rtl/imem_fetch_arbiter.sv | 168 ++++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch sequencer and its write arbiter.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_t;

  localparam int unsigned IMEM_DEPTH   = 256;
  localparam int unsigned IMEM_AW      = 8;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/imem_write_arb.sv
// Combinational arbitration of the memory write port between the program loader and fetch.
module imem_write_arb
  import imem_pkg::*;
#(
  parameter int unsigned AW = IMEM_AW
) (
  input  logic          en,
  input  fetch_state_t  state,
  input  logic          stall,
  input  logic          redirect,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  output logic          grant,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata
);

  always_comb begin
    ld_ready = 1'b1;
    case (state)
      // Fetch owns the bank unless the pipeline is frozen and not being redirected.
      ST_RUN:  ld_ready = stall && !redirect;
      default: ld_ready = 1'b1;
    endcase
    grant     = en && ld_valid && ld_ready;
    mem_we    = grant;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Fetch sequencer: owns the PC, drives the memory read side and the IF/ID register pair.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module imem_fetch_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = IMEM_DEPTH,
  parameter int unsigned AW       = IMEM_AW,
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          mem_read,
  output logic [31:0]   mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [31:0]   ifid_inst,
  output logic [31:0]   ifid_pc4,
  output logic          ifid_valid,
  output logic [31:0]   pc,
  output logic          halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_fetched
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         ld_grant;
  logic         ld_done;
  logic         fault;
  logic         fetch_adv;

  imem_write_arb #(.AW(AW)) u_write_arb (
    .en        (rst_n),
    .state     (state_q),
    .stall     (stall),
    .redirect  (redirect),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .grant     (ld_grant),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  assign ld_done   = ld_grant && ld_last;
  assign fault     = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= 32'(DEPTH));
  assign fetch_adv = (state_q == ST_RUN) && !redirect && !stall && !fault;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_done) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          inst_d  = NOP;
          valid_d = 1'b0;
        end else if (!stall) begin
          if (fault) begin
            state_d = ST_HALT;
            inst_d  = NOP;
            valid_d = 1'b0;
          end else begin
            inst_d  = mem_rdata;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      ST_HALT: begin
        if (ld_done) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
          inst_d  = NOP;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign mem_read   = (state_q == ST_RUN);
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign ifid_inst  = inst_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign halted     = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_fetched_q, perf_fetched_d;

  always_comb begin
    perf_cycles_d  = perf_cycles_q;
    perf_fetched_d = perf_fetched_q;
    // Entering RUN from LOAD or HALT starts a fresh measurement window.
    if (state_q != ST_RUN && state_d == ST_RUN) begin
      perf_cycles_d  = '0;
      perf_fetched_d = '0;
    end else begin
      if (state_q == ST_RUN && perf_cycles_q != '1)
        perf_cycles_d = perf_cycles_q + 32'd1;
      if (fetch_adv && perf_fetched_q != '1)
        perf_fetched_d = perf_fetched_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q  <= '0;
      perf_fetched_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_fetched_q <= perf_fetched_d;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_fetched = perf_fetched_q;
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Self-checking bench for imem_fetch_arbiter: cycle table with a scoreboard queue plus reset sequences.
module tb_imem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_ready, ld_last;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        mem_read, mem_we;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic [7:0]  mem_waddr;
  logic [31:0] ifid_inst, ifid_pc4, pc;
  logic        ifid_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_fetched;
`endif

  always #5 clk = ~clk;

  imem_fetch_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .ifid_inst   (ifid_inst),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .pc          (pc),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_fetched(perf_fetched)
`endif
  );

  // Memory bank model: synchronous write, combinational read.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  typedef struct {
    logic        st, rd;
    logic [31:0] rpc;
    logic        lv;
    logic [7:0]  la;
    logic [31:0] ld;
    logic        ll;
    logic        e_rdy, e_we;
    logic [31:0] e_pc, e_inst, e_pc4;
    logic        e_val, e_halt, e_rd;
  } vec_t;

  typedef struct {
    logic [31:0] pc, inst, pc4;
    logic        val, halt, rd;
  } exp_t;

  vec_t tbl[25];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic lv, input logic [7:0] la, input logic [31:0] ld,
                              input logic ll, input logic e_rdy, input logic e_we,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic [31:0] e_pc4, input logic e_val,
                              input logic e_halt, input logic e_rd);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.lv = lv; v.la = la; v.ld = ld; v.ll = ll;
    v.e_rdy = e_rdy; v.e_we = e_we; v.e_pc = e_pc; v.e_inst = e_inst; v.e_pc4 = e_pc4;
    v.e_val = e_val; v.e_halt = e_halt; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_inst"}, ifid_inst, 32'h0);
    chk({tag, "_pc4"}, {31'b0, 1'b0} | ifid_pc4, 32'h0);
    chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'h0);
    chk({tag, "_mem_read"}, {31'b0, mem_read}, 32'h0);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
    chk({tag, "_ld_ready"}, {31'b0, ld_ready}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_perf_cycles"}, perf_cycles, 32'h0);
    chk({tag, "_perf_fetched"}, perf_fetched, 32'h0);
`endif
  endtask

  localparam logic [31:0] W4   = 32'hC0DE_0004;
  localparam logic [31:0] W16  = 32'hC0DE_0010;
  localparam logic [31:0] W255 = 32'hC0DE_00FF;

  initial begin
    exp_t e;
    string nm;

    //            st rd rpc       lv la  ld            ll rdy we  pc      inst          pc4     val hlt rd
    tbl[0]  = mk(0, 0, 32'h0,    1, 0, 32'h1111_0000, 0, 1, 1, 32'h0,   32'h0,        32'h0,  0, 0, 0);
    tbl[1]  = mk(0, 0, 32'h0,    1, 1, 32'h1111_0001, 0, 1, 1, 32'h0,   32'h0,        32'h0,  0, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,    1, 2, 32'h1111_0002, 0, 1, 1, 32'h0,   32'h0,        32'h0,  0, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0,    1, 3, 32'h1111_0003, 1, 1, 1, 32'h0,   32'h0,        32'h0,  0, 0, 1);
    tbl[4]  = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h4,   32'h1111_0000, 32'h4, 1, 0, 1);
    tbl[5]  = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h8,   32'h1111_0001, 32'h8, 1, 0, 1);
    tbl[6]  = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'hC,   32'h1111_0002, 32'hC, 1, 0, 1);
    tbl[7]  = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h10,  32'h1111_0003, 32'h10, 1, 0, 1);
    tbl[8]  = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h14,  W4,           32'h14, 1, 0, 1);
    tbl[9]  = mk(1, 0, 32'h0,    1, 5, 32'h1111_0005, 0, 1, 1, 32'h14,  W4,           32'h14, 1, 0, 1);
    tbl[10] = mk(1, 0, 32'h0,    0, 0, 32'h0,         0, 1, 0, 32'h14,  W4,           32'h14, 1, 0, 1);
    tbl[11] = mk(1, 0, 32'h0,    0, 0, 32'h0,         0, 1, 0, 32'h14,  W4,           32'h14, 1, 0, 1);
    tbl[12] = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h18,  32'h1111_0005, 32'h18, 1, 0, 1);
    tbl[13] = mk(1, 1, 32'h40,   0, 0, 32'h0,         0, 0, 0, 32'h40,  32'h0,        32'h0,  0, 0, 1);
    tbl[14] = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h44,  W16,          32'h44, 1, 0, 1);
    tbl[15] = mk(0, 1, 32'h3FC,  0, 0, 32'h0,         0, 0, 0, 32'h3FC, 32'h0,        32'h0,  0, 0, 1);
    tbl[16] = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h400, W255,         32'h400, 1, 0, 1);
    tbl[17] = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h400, 32'h0,        32'h0,  0, 1, 0);
    tbl[18] = mk(1, 1, 32'h42,   0, 0, 32'h0,         0, 1, 0, 32'h400, 32'h0,        32'h0,  0, 1, 0);
    tbl[19] = mk(0, 0, 32'h0,    1, 0, 32'h2222_0000, 1, 1, 1, 32'h0,   32'h0,        32'h0,  0, 0, 1);
    tbl[20] = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h4,   32'h2222_0000, 32'h4, 1, 0, 1);
    tbl[21] = mk(0, 1, 32'h42,   0, 0, 32'h0,         0, 0, 0, 32'h42,  32'h0,        32'h0,  0, 0, 1);
    tbl[22] = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h42,  32'h0,        32'h0,  0, 1, 0);
    tbl[23] = mk(0, 0, 32'h0,    1, 1, 32'h2222_0001, 1, 1, 1, 32'h0,   32'h0,        32'h0,  0, 0, 1);
    tbl[24] = mk(0, 0, 32'h0,    0, 0, 32'h0,         0, 0, 0, 32'h4,   32'h2222_0000, 32'h4, 1, 0, 1);

    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      stall = tbl[i].st; redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
      ld_valid = tbl[i].lv; ld_addr = tbl[i].la; ld_data = tbl[i].ld; ld_last = tbl[i].ll;
      #1;
      nm = $sformatf("v%0d", i);
      chk({nm, "_ld_ready"}, {31'b0, ld_ready}, {31'b0, tbl[i].e_rdy});
      chk({nm, "_mem_we"}, {31'b0, mem_we}, {31'b0, tbl[i].e_we});
      if (tbl[i].e_we) chk({nm, "_mem_waddr"}, {24'b0, mem_waddr}, {24'b0, tbl[i].la});
      e.pc = tbl[i].e_pc; e.inst = tbl[i].e_inst; e.pc4 = tbl[i].e_pc4;
      e.val = tbl[i].e_val; e.halt = tbl[i].e_halt; e.rd = tbl[i].e_rd;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL %s_scoreboard: got empty queue want one entry", nm);
      end else begin
        e = sbq.pop_front();
        chk({nm, "_pc"}, pc, e.pc);
        chk({nm, "_mem_addr"}, mem_addr, e.pc);
        chk({nm, "_inst"}, ifid_inst, e.inst);
        if (e.val) chk({nm, "_pc4"}, ifid_pc4, e.pc4);
        chk({nm, "_valid"}, {31'b0, ifid_valid}, {31'b0, e.val});
        chk({nm, "_halted"}, {31'b0, halted}, {31'b0, e.halt});
        chk({nm, "_mem_read"}, {31'b0, mem_read}, {31'b0, e.rd});
      end
    end

`ifdef FETCH_PERF_CNT_EN
    // One RUN cycle with one advance since the HALT->RUN reload.
    chk("perf_cycles_after_reload", perf_cycles, 32'h1);
    chk("perf_fetched_after_reload", perf_fetched, 32'h1);
`endif

    // Reset asserted while running.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_reset_values("rst_mid_run");
    @(negedge clk);
    rst_n = 1'b1;

    // Load two words, then assert reset while the loader is still offering a third.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 8'(32 + i); ld_data = 32'h3333_0000 | 32'(i); ld_last = 1'b0;
      #1;
      chk($sformatf("midload_w%0d_mem_we", i), {31'b0, mem_we}, 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("midload_w%0d_mem_read", i), {31'b0, mem_read}, 32'h0);
    end
    @(negedge clk);
    ld_addr = 8'd34; ld_data = 32'h3333_0002;
    rst_n = 1'b0;
    #1;
    chk_reset_values("rst_mid_load");
    chk("mem_untouched_w32", mem[32], 32'h3333_0000);
    chk("mem_untouched_w34", mem[34], 32'hC0DE_0022);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
